core_exec_sequencer: RTL and testbench
======================================

CORE_EXEC_SEQUENCER -- requirements
Module: core_exec_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: number of CCLK cycles CORE_RST is held on each start.
REQ-002 SHALL have parameter WDOG_W, default 24: run watchdog width; timeout at count 2^WDOG_W-1.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port CCLK, input, 1: sole clock.
REQ-005 SHALL have port CRSTN, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port CRST, input, 1: synchronous soft reset from the AXI controller, active high.
REQ-007 SHALL have port CEXEC, input, 1: execute request level from the controller.
REQ-008 SHALL have port CMEM_ADDR, input, 32: program start address.
REQ-009 SHALL have port CSTAT, output, 8: registered status back to the controller.
REQ-010 SHALL have port CORE_RST, output, 1: core reset, active high.
REQ-011 SHALL have port CORE_EN, output, 1: core clock-enable.
REQ-012 SHALL have port CORE_PC_LOAD, output, 1: one-cycle PC load strobe.
REQ-013 SHALL have port CORE_PC_INIT, output, 32: latched start address.
REQ-014 SHALL have port CORE_HALT, input, 1: core executed halt.
REQ-015 SHALL have port CORE_ERR, input, 1: core illegal-instruction or bus error.

Function
REQ-016 SHALL implement states IDLE=0, RESET=1, LOAD=2, RUN=3, DONE=4, FAULT=5.
REQ-017 IDLE: on a CEXEC rising edge (CEXEC=1, previous-cycle CEXEC=0) SHALL latch CMEM_ADDR into CORE_PC_INIT, clear all flags, and enter RESET.
REQ-018 Start with CMEM_ADDR[1:0]!=0 SHALL go to FAULT with misalign flag set; CORE_RST, CORE_PC_LOAD, CORE_EN stay unchanged.
REQ-019 RESET: CORE_RST=1 for exactly RST_CYCLES cycles, then LOAD.
REQ-020 LOAD: CORE_PC_LOAD=1 for exactly one cycle, then RUN.
REQ-021 RUN: CORE_EN=1; watchdog increments each RUN cycle, saturating, cleared on every start.
REQ-022 RUN exit priority, evaluated each cycle:
- CORE_ERR -> FAULT, err=1
- CORE_HALT -> DONE, done=1
- watchdog == 2^WDOG_W-1 -> FAULT, timeout=1
- CEXEC=0 -> IDLE, abort=1
REQ-023 CORE_EN SHALL be 0 in the cycle after leaving RUN.
REQ-024 DONE/FAULT: hold until CEXEC=0, then go to IDLE; flags persist until the next start.
REQ-025 CEXEC held high through DONE/FAULT/IDLE SHALL NOT restart; a new rising edge is required.
REQ-026 CRST=1 in any state:
- next state IDLE, flags cleared, watchdog cleared
- CORE_RST=1 and CORE_EN=0 while CRST=1
- CRST has priority over all transitions.
REQ-027 CSTAT layout: [2:0] state, [3] done, [4] err, [5] timeout, [6] misalign, [7] abort; registered, updated the cycle after the cause.
REQ-028 CORE_HALT/CORE_ERR outside RUN SHALL be ignored.

Reset
REQ-029 On CRSTN=0, asynchronously:
- state=IDLE, CSTAT=0x00
- CORE_RST=1, CORE_EN=0, CORE_PC_LOAD=0, CORE_PC_INIT=0
- counters 0, CEXEC history=1 (no spurious start when CEXEC is already high at release).
REQ-030 After CRSTN deasserts, CORE_RST SHALL drop to 0 on the first clock edge in IDLE.
REQ-031 CRSTN asserted mid-RUN SHALL immediately force the REQ-029 values.

Structure
REQ-032 Package core_exec_pkg SHALL hold the state encoding and the CSTAT bit indices, shared with the controller's software header generation.
REQ-033 The watchdog SHALL be sub-module core_exec_wdog (clear, enable, saturate, terminal-count output, WDOG_W parameter); all else stays in one module.

Verification
REQ-034 Start at 0x00000100 with WDOG_W=8, RST_CYCLES=4; CORE_HALT after 10 RUN cycles -> CORE_RST high 4 cycles, one PC_LOAD with PC_INIT=0x100, CSTAT=0x0C; CEXEC=0 -> CSTAT=0x08.
REQ-035 CMEM_ADDR=0x102 on CEXEC edge -> CSTAT=0x45, no CORE_RST or PC_LOAD pulse.
REQ-036 WDOG_W=4, no halt -> FAULT after exactly 15 RUN cycles, CSTAT=0x25, CORE_EN low the next cycle.
REQ-037 CORE_ERR and CORE_HALT in the same RUN cycle -> CSTAT=0x15.
REQ-038 CRST pulse mid-RUN, then CEXEC dropped mid-RUN on a second start -> CSTAT=0x00 after CRST; CSTAT=0x80 after the abort.
REQ-039 CRSTN released with CEXEC already high -> stays in IDLE; toggling CEXEC low then high starts a run.

Source files
------------

// File: rtl/core_exec_pkg.sv
// Shared definitions for the core execution sequencer: state encoding and
// CSTAT bit positions, also consumed by the controller's header generator.
package core_exec_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_DONE      = 3;
  localparam int STAT_ERR       = 4;
  localparam int STAT_TIMEOUT   = 5;
  localparam int STAT_MISALIGN  = 6;
  localparam int STAT_ABORT     = 7;

  // Field order matches CSTAT[7:3] when packed above the state.
  typedef struct packed {
    logic abort;
    logic misalign;
    logic timeout;
    logic err;
    logic done;
  } flags_t;

  function automatic logic [7:0] pack_stat(state_t s, flags_t f);
    return {f, s};
  endfunction

endpackage

// File: rtl/core_exec_wdog.sv
// Run watchdog: saturating up-counter with synchronous clear and a
// terminal-count flag raised at the all-ones value.
module core_exec_wdog #(
  parameter int WDOG_W = 24
) (
  input  logic CCLK,
  input  logic CRSTN,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WDOG_W-1:0] cnt_q;

  assign tc = &cnt_q;

  // Count enabled cycles, hold at terminal count, clear has priority.
  always_ff @(posedge CCLK or negedge CRSTN) begin
    if (!CRSTN)          cnt_q <= '0;
    else if (clr)        cnt_q <= '0;
    else if (en && !tc)  cnt_q <= cnt_q + {{(WDOG_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/core_exec_sequencer.sv
// Core execution sequencer: on a CEXEC rising edge it resets the core, loads
// the start PC, runs it under a watchdog, and reports the outcome in CSTAT.
module core_exec_sequencer
  import core_exec_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int WDOG_W     = 24
) (
  input  logic        CCLK,
  input  logic        CRSTN,
  input  logic        CRST,
  input  logic        CEXEC,
  input  logic [31:0] CMEM_ADDR,
  output logic [7:0]  CSTAT,
  output logic        CORE_RST,
  output logic        CORE_EN,
  output logic        CORE_PC_LOAD,
  output logic [31:0] CORE_PC_INIT,
  input  logic        CORE_HALT,
  input  logic        CORE_ERR
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  state_t          state_q, state_d;
  flags_t          flags_q, flags_d;
  logic            cexec_q;
  logic [RCW-1:0]  rst_cnt_q;
  logic [31:0]     pc_q;
  logic            core_rst_q, core_en_q, pc_load_q;
  logic            core_rst_d, core_en_d, pc_load_d;
  logic            start, wdog_tc;

  // Only a fresh edge in IDLE starts; a level held across DONE/FAULT does not.
  assign start = (state_q == S_IDLE) && CEXEC && !cexec_q && !CRST;

  core_exec_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .CCLK  (CCLK),
    .CRSTN (CRSTN),
    .clr   (start || CRST),
    .en    (state_d == S_RUN),
    .tc    (wdog_tc)
  );

  // State, flags, counters and registered core controls.
  always_ff @(posedge CCLK or negedge CRSTN) begin
    if (!CRSTN) begin
      state_q    <= S_IDLE;
      flags_q    <= '0;
      cexec_q    <= 1'b1;
      rst_cnt_q  <= '0;
      pc_q       <= '0;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      pc_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      cexec_q    <= CEXEC;
      rst_cnt_q  <= (state_q == S_RESET && state_d == S_RESET) ? rst_cnt_q + 1'b1 : '0;
      if (start) pc_q <= CMEM_ADDR;
      core_rst_q <= core_rst_d;
      core_en_q  <= core_en_d;
      pc_load_q  <= pc_load_d;
    end
  end

  // Next state and flag updates; CRST overrides everything.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    if (CRST) begin
      state_d = S_IDLE;
      flags_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          flags_d = '0;
          if (|CMEM_ADDR[1:0]) begin
            state_d          = S_FAULT;
            flags_d.misalign = 1'b1;
          end else begin
            state_d = S_RESET;
          end
        end
        S_RESET: if (rst_cnt_q == RST_LAST) state_d = S_LOAD;
        S_LOAD:  state_d = S_RUN;
        S_RUN: begin
          if (CORE_ERR) begin
            state_d     = S_FAULT;
            flags_d.err = 1'b1;
          end else if (CORE_HALT) begin
            state_d      = S_DONE;
            flags_d.done = 1'b1;
          end else if (wdog_tc) begin
            state_d         = S_FAULT;
            flags_d.timeout = 1'b1;
          end else if (!CEXEC) begin
            state_d       = S_IDLE;
            flags_d.abort = 1'b1;
          end
        end
        S_DONE, S_FAULT: if (!CEXEC) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Core controls follow the state being entered, so they line up with it.
  always_comb begin
    core_rst_d = (state_d == S_RESET);
    core_en_d  = (state_d == S_RUN);
    pc_load_d  = (state_d == S_LOAD);
  end

  // Soft reset acts on the core immediately, not a cycle late.
  assign CORE_RST     = core_rst_q | CRST;
  assign CORE_EN      = core_en_q & ~CRST;
  assign CORE_PC_LOAD = pc_load_q;
  assign CORE_PC_INIT = pc_q;
  assign CSTAT        = pack_stat(state_q, flags_q);

endmodule

// File: tb/tb_core_exec_sequencer.sv
// Directed bench for core_exec_sequencer: a per-cycle vector table plus
// hand-written sequences around the asynchronous reset.
module tb_core_exec_sequencer;

  logic        CCLK = 1'b0;
  logic        CRSTN, CRST, CEXEC, CORE_HALT, CORE_ERR;
  logic [31:0] CMEM_ADDR;
  logic [7:0]  CSTAT;
  logic        CORE_RST, CORE_EN, CORE_PC_LOAD;
  logic [31:0] CORE_PC_INIT;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          rep;
    logic        crst, cexec;
    logic [31:0] addr;
    logic        halt, err;
    logic [7:0]  stat;
    logic        rst, en, pcl;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  always #5 CCLK = ~CCLK;

  core_exec_sequencer #(.RST_CYCLES(4), .WDOG_W(4)) dut (
    .CCLK         (CCLK),
    .CRSTN        (CRSTN),
    .CRST         (CRST),
    .CEXEC        (CEXEC),
    .CMEM_ADDR    (CMEM_ADDR),
    .CSTAT        (CSTAT),
    .CORE_RST     (CORE_RST),
    .CORE_EN      (CORE_EN),
    .CORE_PC_LOAD (CORE_PC_LOAD),
    .CORE_PC_INIT (CORE_PC_INIT),
    .CORE_HALT    (CORE_HALT),
    .CORE_ERR     (CORE_ERR)
  );

  task automatic add(input int rep, input logic crst, input logic cexec,
                     input logic [31:0] addr, input logic halt, input logic err,
                     input logic [7:0] stat, input logic rst, input logic en,
                     input logic pcl, input logic [31:0] pc);
    vec_t v;
    v.rep = rep; v.crst = crst; v.cexec = cexec; v.addr = addr;
    v.halt = halt; v.err = err; v.stat = stat; v.rst = rst; v.en = en;
    v.pcl = pcl; v.pc = pc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] st, input logic r,
                     input logic e, input logic p, input logic [31:0] pc);
    total++;
    if (CSTAT !== st || CORE_RST !== r || CORE_EN !== e ||
        CORE_PC_LOAD !== p || CORE_PC_INIT !== pc) begin
      bad++;
      $display("FAIL %s: got stat=%h rst=%b en=%b pcl=%b pc=%h, want stat=%h rst=%b en=%b pcl=%b pc=%h",
               nm, CSTAT, CORE_RST, CORE_EN, CORE_PC_LOAD, CORE_PC_INIT,
               st, r, e, p, pc);
    end
  endtask

  task automatic cyc(input logic cexec, input logic [31:0] addr);
    CEXEC = cexec; CMEM_ADDR = addr;
    @(posedge CCLK); #1;
  endtask

  initial begin
    CRSTN = 1'b0; CRST = 1'b0; CEXEC = 1'b0; CMEM_ADDR = '0;
    CORE_HALT = 1'b0; CORE_ERR = 1'b0;

    // halt after 10 RUN cycles at 0x100
    add(1,  0,0,32'h100,0,0, 8'h00,0,0,0, 32'h0);
    add(4,  0,1,32'h100,0,0, 8'h01,1,0,0, 32'h100);
    add(1,  0,1,32'h100,0,0, 8'h02,0,0,1, 32'h100);
    add(10, 0,1,32'h100,0,0, 8'h03,0,1,0, 32'h100);
    add(1,  0,1,32'h100,1,0, 8'h0C,0,0,0, 32'h100);
    add(1,  0,1,32'h100,0,0, 8'h0C,0,0,0, 32'h100);
    add(2,  0,0,32'h100,0,0, 8'h08,0,0,0, 32'h100);
    // misaligned start
    add(2,  0,1,32'h102,0,0, 8'h45,0,0,0, 32'h102);
    add(1,  0,0,32'h102,0,0, 8'h40,0,0,0, 32'h102);
    // watchdog timeout after exactly 15 RUN cycles
    add(4,  0,1,32'h200,0,0, 8'h01,1,0,0, 32'h200);
    add(1,  0,1,32'h200,0,0, 8'h02,0,0,1, 32'h200);
    add(15, 0,1,32'h200,0,0, 8'h03,0,1,0, 32'h200);
    add(1,  0,1,32'h200,0,0, 8'h25,0,0,0, 32'h200);
    add(1,  0,0,32'h200,0,0, 8'h20,0,0,0, 32'h200);
    // err and halt together, then both ignored in IDLE
    add(4,  0,1,32'h300,0,0, 8'h01,1,0,0, 32'h300);
    add(1,  0,1,32'h300,0,0, 8'h02,0,0,1, 32'h300);
    add(3,  0,1,32'h300,0,0, 8'h03,0,1,0, 32'h300);
    add(1,  0,1,32'h300,1,1, 8'h15,0,0,0, 32'h300);
    add(1,  0,0,32'h300,0,0, 8'h10,0,0,0, 32'h300);
    add(2,  0,0,32'h300,1,1, 8'h10,0,0,0, 32'h300);
    // soft reset mid-RUN, held CEXEC must not restart
    add(4,  0,1,32'h400,0,0, 8'h01,1,0,0, 32'h400);
    add(1,  0,1,32'h400,0,0, 8'h02,0,0,1, 32'h400);
    add(2,  0,1,32'h400,0,0, 8'h03,0,1,0, 32'h400);
    add(2,  1,1,32'h400,0,0, 8'h00,1,0,0, 32'h400);
    add(2,  0,1,32'h400,0,0, 8'h00,0,0,0, 32'h400);
    add(1,  0,0,32'h400,0,0, 8'h00,0,0,0, 32'h400);
    // abort by dropping CEXEC mid-RUN
    add(4,  0,1,32'h500,0,0, 8'h01,1,0,0, 32'h500);
    add(1,  0,1,32'h500,0,0, 8'h02,0,0,1, 32'h500);
    add(3,  0,1,32'h500,0,0, 8'h03,0,1,0, 32'h500);
    add(2,  0,0,32'h500,0,0, 8'h80,0,0,0, 32'h500);

    repeat (3) @(posedge CCLK);
    #1 chk("reset_values", 8'h00, 1, 0, 0, 32'h0);
    @(negedge CCLK) CRSTN = 1'b1;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        CRST = tbl[i].crst; CEXEC = tbl[i].cexec; CMEM_ADDR = tbl[i].addr;
        CORE_HALT = tbl[i].halt; CORE_ERR = tbl[i].err;
        @(posedge CCLK); #1;
        chk($sformatf("vec%0d_c%0d", i, k), tbl[i].stat, tbl[i].rst,
            tbl[i].en, tbl[i].pcl, tbl[i].pc);
      end
    end
    CORE_HALT = 1'b0; CORE_ERR = 1'b0; CRST = 1'b0;

    // asynchronous reset mid-RUN with CEXEC left high
    repeat (7) cyc(1'b1, 32'h600);
    chk("run_before_arst", 8'h03, 0, 1, 0, 32'h600);
    #2 CRSTN = 1'b0;
    #1 chk("arst_mid_run", 8'h00, 1, 0, 0, 32'h0);
    @(negedge CCLK) CRSTN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h600);
      chk($sformatf("no_start_after_arst%0d", k), 8'h00, 0, 0, 0, 32'h0);
    end
    cyc(1'b0, 32'h600);
    chk("cexec_low", 8'h00, 0, 0, 0, 32'h0);
    cyc(1'b1, 32'h600);
    chk("restart_after_toggle", 8'h01, 1, 0, 0, 32'h600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
